alu_share_arbiter: RTL and testbench

- Shares one combinational ALU between two requesters (req0, req1) with a valid/ready handshake on requests and responses.
- Round-robin arbitration: one operation in flight at a time, operands registered before driving the ALU, result registered and returned only to the granted requester.
- Sits between the two issuing units and the ALU instance; the ALU-side ports map directly onto ALU operandA/operandB/operation/aluResult.

---
 rtl/alu_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters.
// Each request and each response uses a valid/ready handshake.
// Arbitration is round-robin with a single operation in flight.
// The FSM walks IDLE -> EXEC -> RESP: accept and latch the operands,
// capture the ALU result, then hold the response until it is taken.
// Peak throughput is one operation every three cycles.

module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Requester 0
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_opA,
    input  logic [DATA_WIDTH-1:0] req0_opB,
    input  logic [OP_WIDTH-1:0]   req0_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,

    // Requester 1
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_opA,
    input  logic [DATA_WIDTH-1:0] req1_opB,
    input  logic [OP_WIDTH-1:0]   req1_op,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,

    // Shared ALU
    output logic [DATA_WIDTH-1:0] alu_operandA,
    output logic [DATA_WIDTH-1:0] alu_operandB,
    output logic [OP_WIDTH-1:0]   alu_operation,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic                  last_grant_q;   // requester served most recently
    logic                  grant_q;        // requester owning the in-flight op
    logic [DATA_WIDTH-1:0] opa_q;
    logic [DATA_WIDTH-1:0] opb_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  rsp0_valid_q;
    logic                  rsp1_valid_q;

    // Arbitration terms, used only while IDLE
    logic                  grant_d;        // requester that would be granted now
    logic                  accept_d;       // a handshake completes at this edge
    logic                  rsp_done_d;     // response handshake completes at this edge

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        grant_d = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_d = ~last_grant_q;
        end else if (req1_valid) begin
            grant_d = 1'b1;
        end else begin
            grant_d = 1'b0;
        end
    end

    // Ready goes to at most one requester, and only while the ALU is free
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == IDLE) begin
            req0_ready = req0_valid && !grant_d;
            req1_ready = req1_valid &&  grant_d;
        end
    end

    // A handshake completes when the chosen side has both valid and ready
    always_comb begin
        accept_d   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        // rsp*_ready only counts while the matching rsp*_valid is high
        rsp_done_d = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);
    end

    // Control FSM plus the operand, opcode and result registers it owns
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;   // requester 0 wins the first tie
            grant_q      <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= '0;
            result_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        opa_q        <= grant_d ? req1_opA : req0_opA;
                        opb_q        <= grant_d ? req1_opB : req0_opB;
                        op_q         <= grant_d ? req1_op  : req0_op;
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU has seen the latched operands for a full cycle
                    result_q     <= alu_result;
                    rsp0_valid_q <= ~grant_q;
                    rsp1_valid_q <=  grant_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_done_d) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    // The ALU is fed only from registers, so there is no req-to-ALU combinational path
    always_comb begin
        alu_operandA  = opa_q;
        alu_operandB  = opb_q;
        alu_operation = op_q;
    end

    // Response outputs come straight from registers
    always_comb begin
        rsp0_valid  = rsp0_valid_q;
        rsp1_valid  = rsp1_valid_q;
        rsp0_result = result_q;
        rsp1_result = result_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter.
// A small behavioural ALU model closes the loop on the ALU ports.
// Every check runs through chk().

module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    // ALU op encoding used by the model
    localparam logic [OW-1:0] OP_AND = 4'h0;
    localparam logic [OW-1:0] OP_OR  = 4'h1;
    localparam logic [OW-1:0] OP_ADD = 4'h2;
    localparam logic [OW-1:0] OP_SUB = 4'h6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [DW-1:0] req0_opA, req0_opB, rsp0_result;
    logic [OW-1:0] req0_op;
    logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [DW-1:0] req1_opA, req1_opB, rsp1_result;
    logic [OW-1:0] req1_op;
    logic [DW-1:0] alu_operandA, alu_operandB, alu_result;
    logic [OW-1:0] alu_operation;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_opA      (req0_opA),
        .req0_opB      (req0_opB),
        .req0_op       (req0_op),
        .rsp0_valid    (rsp0_valid),
        .rsp0_ready    (rsp0_ready),
        .rsp0_result   (rsp0_result),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_opA      (req1_opA),
        .req1_opB      (req1_opB),
        .req1_op       (req1_op),
        .rsp1_valid    (rsp1_valid),
        .rsp1_ready    (rsp1_ready),
        .rsp1_result   (rsp1_result),
        .alu_operandA  (alu_operandA),
        .alu_operandB  (alu_operandB),
        .alu_operation (alu_operation),
        .alu_result    (alu_result)
    );

    // Behavioural ALU model standing in for the real ALU
    always_comb begin
        case (alu_operation)
            OP_AND:  alu_result = alu_operandA & alu_operandB;
            OP_OR:   alu_result = alu_operandA | alu_operandB;
            OP_ADD:  alu_result = alu_operandA + alu_operandB;
            OP_SUB:  alu_result = alu_operandA - alu_operandB;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_opA = 0; req0_opB = 0; req0_op = 0; rsp0_ready = 0;
        req1_valid = 0; req1_opA = 0; req1_opB = 0; req1_op = 0; rsp1_ready = 0;
        do_reset();

        // Reset state
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_aluA", alu_operandA, 0);
        chk("rst_result", rsp0_result, 0);

        // Single request on port 0: ADD 5 + 7
        req0_valid = 1; req0_opA = 5; req0_opB = 7; req0_op = OP_ADD; rsp0_ready = 1;
        #1;
        chk("t1_req0_ready", req0_ready, 1);
        chk("t1_req1_ready", req1_ready, 0);
        tick();                              // accept
        req0_valid = 0;
        #1;
        chk("t1_exec_aluA", alu_operandA, 5);
        chk("t1_exec_aluB", alu_operandB, 7);
        chk("t1_exec_ready", req0_ready, 0);
        tick();                              // result captured
        chk("t1_rsp0_valid", rsp0_valid, 1);
        chk("t1_rsp0_result", rsp0_result, 12);
        chk("t1_rsp1_valid", rsp1_valid, 0);
        tick();                              // response taken
        chk("t1_rsp0_done", rsp0_valid, 0);

        // Both requesters valid throughout: grants alternate 0,1,0,1
        do_reset();
        req0_valid = 1; req0_opA = 10; req0_opB = 3; req0_op = OP_SUB;
        req1_valid = 1; req1_opA = 1;  req1_opB = 1; req1_op = OP_ADD;
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = logic'(i % 2);
            chk($sformatf("t2_ready0_%0d", i), req0_ready, {31'b0, ~g});
            chk($sformatf("t2_ready1_%0d", i), req1_ready, {31'b0, g});
            tick();                          // accept
            chk($sformatf("t2_busy0_%0d", i), req0_ready, 0);
            tick();                          // capture
            chk($sformatf("t2_rsp0v_%0d", i), rsp0_valid, {31'b0, ~g});
            chk($sformatf("t2_rsp1v_%0d", i), rsp1_valid, {31'b0, g});
            chk($sformatf("t2_res_%0d", i), g ? rsp1_result : rsp0_result, g ? 32'd2 : 32'd7);
            tick();                          // response taken
        end
        req0_valid = 0; req1_valid = 0;

        // Backpressure on port 1 while port 0 waits
        req1_valid = 1; req1_opA = 32'hF0; req1_opB = 32'h0F; req1_op = OP_OR; rsp1_ready = 0;
        #1;
        chk("t3_req1_ready", req1_ready, 1);
        tick();                              // accept req1
        req1_valid = 0;
        req0_valid = 1; req0_opA = 2; req0_opB = 3; req0_op = OP_ADD; rsp0_ready = 1;
        tick();                              // capture
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_rsp1v_%0d", i), rsp1_valid, 1);
            chk($sformatf("t3_rsp1r_%0d", i), rsp1_result, 32'h0000_00FF);
            chk($sformatf("t3_req0r_%0d", i), req0_ready, 0);
            chk($sformatf("t3_rsp0v_%0d", i), rsp0_valid, 0);
            tick();
        end
        rsp1_ready = 1;
        #1;
        chk("t3_req0r_before_done", req0_ready, 0);
        tick();                              // response 1 taken
        chk("t3_rsp1_done", rsp1_valid, 0);
        chk("t3_req0r_after", req0_ready, 1);
        tick();                              // accept req0
        req0_valid = 0;
        tick();
        chk("t3_rsp0v", rsp0_valid, 1);
        chk("t3_rsp0r", rsp0_result, 5);
        tick();

        // Idle hold after an AND
        req0_valid = 1; req0_opA = 32'hF0F0; req0_opB = 32'h0FF0; req0_op = OP_AND;
        tick();                              // accept
        req0_valid = 0;
        tick();
        chk("t4_result", rsp0_result, 32'h00F0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_aluA_%0d", i), alu_operandA, 32'hF0F0);
            chk($sformatf("t4_aluB_%0d", i), alu_operandB, 32'h0FF0);
            chk($sformatf("t4_rdy_%0d", i), {30'b0, req0_ready, req1_ready}, 0);
            chk($sformatf("t4_vld_%0d", i), {30'b0, rsp0_valid, rsp1_valid}, 0);
            tick();
        end

        // Reset in the middle of EXEC
        req0_valid = 1; req0_opA = 100; req0_opB = 1; req0_op = OP_ADD;
        req1_valid = 1; req1_opA = 200; req1_opB = 1; req1_op = OP_SUB;
        tick();                              // accept (requester 1, since 0 went last)
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        chk("t5e_rsp0v", rsp0_valid, 0);
        chk("t5e_rsp1v", rsp1_valid, 0);
        chk("t5e_aluA", alu_operandA, 0);
        chk("t5e_aluB", alu_operandB, 0);
        chk("t5e_res", rsp1_result, 0);
        chk("t5e_tie0", req0_ready, 1);
        chk("t5e_tie1", req1_ready, 0);
        tick();
        chk("t5e_post_rsp", {30'b0, rsp0_valid, rsp1_valid}, 0);

        // Reset in the middle of RESP
        rst_n = 0; tick(); rst_n = 1; #1;
        rsp0_ready = 0;
        tick();                              // accept req0
        tick();                              // capture
        chk("t5r_rsp0v", rsp0_valid, 1);
        chk("t5r_res", rsp0_result, 101);
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        chk("t5r_rsp0v_after", rsp0_valid, 0);
        chk("t5r_res_after", rsp0_result, 0);
        chk("t5r_tie0", req0_ready, 1);
        chk("t5r_tie1", req1_ready, 0);
        req1_valid = 0;
        rsp0_ready = 1;

        // Wrap-around ADD and 3-cycle spacing of back-to-back accepts
        req0_opA = 32'hFFFF_FFFF; req0_opB = 1; req0_op = OP_ADD;
        #1;
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("t6_ready_c%0d", c), req0_ready, (c % 3 == 0) ? 1 : 0);
            if (c % 3 == 1) begin
                chk($sformatf("t6_rspv_c%0d", c), rsp0_valid, 0);
            end
            if (c % 3 == 2) begin
                chk($sformatf("t6_rspv_c%0d", c), rsp0_valid, 1);
                chk($sformatf("t6_res_c%0d", c), rsp0_result, 32'h0000_0000);
            end
            tick();
        end
        req0_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
